// File: rtl/rcv_bit_ctrl.sv
// Receive-side bit controller: synchronizes the RX line, qualifies the start bit,
// times data bits for the downstream shift register and checks the stop bit.
module rcv_bit_ctrl #(
  parameter int unsigned CLKS_PER_BIT  = 10,
  parameter int unsigned NUM_DATA_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic shift_enable,
  output logic shift_stop,
  output logic load_buffer,
  output logic framing_error,
  output logic rx_busy
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W   = $clog2(NUM_DATA_BITS + 1);

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    LOAD      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic               framing_error_q, framing_error_d;
  logic               shift_enable_q, shift_enable_d;
  logic               shift_stop_q, shift_stop_d;
  logic               load_buffer_q, load_buffer_d;
  logic               rx_busy_q, rx_busy_d;

  logic start_edge;
  logic bit_wrap;

  assign start_edge = s3_q & ~s2_q;
  assign bit_wrap   = (timer_q == BIT_LAST);

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      bit_cnt_q       <= '0;
      s1_q            <= 1'b1;
      s2_q            <= 1'b1;
      s3_q            <= 1'b1;
      framing_error_q <= 1'b0;
      shift_enable_q  <= 1'b0;
      shift_stop_q    <= 1'b0;
      load_buffer_q   <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      bit_cnt_q       <= bit_cnt_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      s3_q            <= s3_d;
      framing_error_q <= framing_error_d;
      shift_enable_q  <= shift_enable_d;
      shift_stop_q    <= shift_stop_d;
      load_buffer_q   <= load_buffer_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  // Next state, timer, bit counter and sticky framing flag
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    framing_error_d = framing_error_q;
    timer_d         = '0;
    s1_d            = serial_in;
    s2_d            = s1_q;
    s3_d            = s2_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = START_CHK;
      end
      START_CHK: begin
        if (timer_q == HALF_LAST) begin
          if (!s2_q) begin
            state_d         = DATA;
            framing_error_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_wrap) begin
          if (bit_cnt_q == CNT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_wrap) begin
          if (s2_q) begin
            state_d = LOAD;
          end else begin
            state_d         = WAIT_HIGH;
            framing_error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      WAIT_HIGH: begin
        if (s2_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timer restarts on every state change and only runs in timed states
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == START_CHK || state_q == DATA || state_q == STOP) begin
      timer_d = bit_wrap ? '0 : timer_q + TIMER_W'(1);
    end
  end

  // Outputs decoded from the next state so the flops line up with state_q
  always_comb begin
    shift_enable_d = 1'b0;
    shift_stop_d   = 1'b0;
    load_buffer_d  = 1'b0;
    rx_busy_d      = (state_d != IDLE);
    unique case (state_d)
      DATA:    shift_enable_d = (timer_d == BIT_LAST);
      STOP:    shift_stop_d   = 1'b1;
      LOAD:    load_buffer_d  = 1'b1;
      default: ;
    endcase
  end

  assign shift_enable  = shift_enable_q;
  assign shift_stop    = shift_stop_q;
  assign load_buffer   = load_buffer_q;
  assign framing_error = framing_error_q;
  assign rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// Directed bench for rcv_bit_ctrl: table of frames plus hand-written corner sequences.
module tb_rcv_bit_ctrl;

  localparam int C = 10;
  localparam int H = C / 2;
  // Pulse offsets measured from the cycle the raw line is driven low (s2 falls 2 cycles later)
  localparam int FIRST_SE = 2 + H + C;
  localparam int LOAD_AT  = 2 + H + 9 * C + 1;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic shift_enable, shift_stop, load_buffer, framing_error, rx_busy;

  rcv_bit_ctrl #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .shift_stop   (shift_stop),
    .load_buffer  (load_buffer),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream shift register model and pulse bookkeeping
  int         se_total = 0;
  int         ld_total = 0;
  int         excl_err = 0;
  int         ld_time  = -1;
  int         se_times[$];
  logic [7:0] shreg = 8'h00;

  always @(negedge clk) begin
    if (shift_enable) begin
      se_total++;
      shreg = {serial_in, shreg[7:1]};
      se_times.push_back(cyc);
    end
    if (load_buffer) begin
      ld_total++;
      ld_time = cyc;
    end
    if (shift_enable && shift_stop) excl_err++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick(C);
    end
    serial_in = stop;
    tick(C);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int c0);
    serial_in = 1'b0;
    c0 = cyc;
    tick(C);
    send_bits(d, stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_se;
    int         exp_ld;
    logic       exp_fe;
    logic [7:0] exp_reg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 cycles left", 0);
    $fatal(1);
  end

  initial begin
    int se0, ld0, base, c0, c1;
    logic [7:0] fb;

    vecs[0] = '{8'hA5, 1'b1, 8, 1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 8, 0, 1'b1, 8'h3C};
    vecs[2] = '{8'h11, 1'b1, 8, 1, 1'b0, 8'h11};
    vecs[3] = '{8'h00, 1'b1, 8, 1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 8, 1, 1'b0, 8'hFF};
    vecs[5] = '{8'h80, 1'b0, 8, 0, 1'b1, 8'h80};
    vecs[6] = '{8'h01, 1'b1, 8, 1, 1'b0, 8'h01};

    // Reset state
    rst = 1'b1;
    serial_in = 1'b1;
    tick(3);
    check("rst_shift_enable", int'(shift_enable), 0);
    check("rst_shift_stop", int'(shift_stop), 0);
    check("rst_load_buffer", int'(load_buffer), 0);
    check("rst_framing_error", int'(framing_error), 0);
    check("rst_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;

    // Idle line for 100 cycles
    se0 = se_total; ld0 = ld_total;
    tick(100);
    check("idle_se", se_total - se0, 0);
    check("idle_ld", ld_total - ld0, 0);
    check("idle_busy", int'(rx_busy), 0);
    check("idle_fe", int'(framing_error), 0);

    // Table of frames
    foreach (vecs[v]) begin
      se0 = se_total; ld0 = ld_total; base = se_times.size(); ld_time = -1;
      send_frame(vecs[v].data, vecs[v].stop, c0);
      serial_in = 1'b1;
      tick(20);
      check($sformatf("v%0d_se_count", v), se_total - se0, vecs[v].exp_se);
      check($sformatf("v%0d_ld_count", v), ld_total - ld0, vecs[v].exp_ld);
      check($sformatf("v%0d_fe", v), int'(framing_error), int'(vecs[v].exp_fe));
      check($sformatf("v%0d_data", v), int'(shreg), int'(vecs[v].exp_reg));
      check($sformatf("v%0d_busy", v), int'(rx_busy), 0);
      check($sformatf("v%0d_first_se", v),
            (se_times.size() > base) ? se_times[base] - c0 : -1, FIRST_SE);
      check($sformatf("v%0d_se_span", v),
            (se_times.size() >= base + 8) ? se_times[base + 7] - se_times[base] : -1, 7 * C);
      if (vecs[v].exp_ld != 0)
        check($sformatf("v%0d_ld_time", v), ld_time - c0, LOAD_AT);
    end

    // Short low glitch is rejected at the start check
    se0 = se_total; ld0 = ld_total;
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(2);
    check("glitch_busy_startchk", int'(rx_busy), 1);
    tick(20);
    check("glitch_se", se_total - se0, 0);
    check("glitch_ld", ld_total - ld0, 0);
    check("glitch_busy_after", int'(rx_busy), 0);

    // Bad stop bit, line held low, then recovery on a good frame
    se0 = se_total; ld0 = ld_total;
    send_frame(8'h3C, 1'b0, c0);
    tick(50);
    check("hold_se", se_total - se0, 8);
    check("hold_ld", ld_total - ld0, 0);
    check("hold_fe", int'(framing_error), 1);
    check("hold_busy", int'(rx_busy), 1);
    serial_in = 1'b1;
    tick(20);
    check("release_busy", int'(rx_busy), 0);
    check("release_fe_sticky", int'(framing_error), 1);
    se0 = se_total; ld0 = ld_total;
    serial_in = 1'b0;
    tick(H);
    check("recover_fe_before_chk", int'(framing_error), 1);
    tick(C - H);
    check("recover_fe_cleared", int'(framing_error), 0);
    send_bits(8'h11, 1'b1);
    serial_in = 1'b1;
    tick(20);
    check("recover_ld", ld_total - ld0, 1);
    check("recover_data", int'(shreg), 8'h11);

    // Reset one cycle after the 4th shift_enable of a frame
    se0 = se_total; ld0 = ld_total;
    fb = 8'hF8;
    c0 = cyc;
    for (int t = 0; t < 10 * C + 20; t++) begin
      if (t < C) serial_in = 1'b0;
      else if (t < 9 * C) serial_in = fb[(t / C) - 1];
      else serial_in = 1'b1;
      rst = (t == FIRST_SE + 3 * C + 1);
      if (t == FIRST_SE + 3 * C + 2) begin
        check("midrst_se_before", se_total - se0, 4);
        check("midrst_shift_enable", int'(shift_enable), 0);
        check("midrst_shift_stop", int'(shift_stop), 0);
        check("midrst_load_buffer", int'(load_buffer), 0);
        check("midrst_fe", int'(framing_error), 0);
        check("midrst_busy", int'(rx_busy), 0);
      end
      tick(1);
    end
    rst = 1'b0;
    check("midrst_se_after", se_total - se0, 4);
    check("midrst_ld_after", ld_total - ld0, 0);
    se0 = se_total; ld0 = ld_total;
    send_frame(8'hFF, 1'b1, c0);
    serial_in = 1'b1;
    tick(20);
    check("postrst_se", se_total - se0, 8);
    check("postrst_ld", ld_total - ld0, 1);
    check("postrst_data", int'(shreg), 8'hFF);

    // Back-to-back frames with no idle gap
    se0 = se_total; ld0 = ld_total;
    send_frame(8'h55, 1'b1, c0);
    send_frame(8'hAA, 1'b1, c1);
    serial_in = 1'b1;
    tick(20);
    check("b2b_se", se_total - se0, 16);
    check("b2b_ld", ld_total - ld0, 2);
    check("b2b_data", int'(shreg), 8'hAA);
    check("b2b_fe", int'(framing_error), 0);
    check("b2b_ld_time", ld_time - c1, LOAD_AT);

    check("se_and_stop_overlap", excl_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
